// File: rtl/csa_final_adder.sv
// Carry-propagate stage for the Booth 8x8 CSA tree: two-stage split adder with valid/ready.
// Optional sideband tag path enabled by defining CSA_TAG_EN.
module csa_final_adder #(
    parameter int CS_W  = 17,
    parameter int P_W   = 16,
    parameter int LO_W  = 8
`ifdef CSA_TAG_EN
    ,
    parameter int TAG_W = 4
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CS_W-1:0] in_vs,
    input  logic [CS_W-1:0] in_vc,
`ifdef CSA_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  out_prod
);
    localparam int HI_W = CS_W - LO_W;

    logic            s1_valid_q, s1_valid_d;
    logic [LO_W-1:0] s1_lo_q,    s1_lo_d;
    logic            s1_cy_q,    s1_cy_d;
    logic [HI_W-1:0] s1_vs_hi_q, s1_vs_hi_d;
    logic [HI_W-1:0] s1_vc_hi_q, s1_vc_hi_d;
    logic            s2_valid_q, s2_valid_d;
    logic [P_W-1:0]  s2_prod_q,  s2_prod_d;
`ifdef CSA_TAG_EN
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
`endif

    logic            s2_adv, s1_adv;
    logic [LO_W:0]   lo_sum;
    logic [HI_W-1:0] hi_sum;
    logic [CS_W-1:0] full_sum;
    // Bits above the product width are a sign-extension artefact and are dropped.
    logic [CS_W-P_W-1:0] unused_top_bits;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign lo_sum          = {1'b0, in_vs[LO_W-1:0]} + {1'b0, in_vc[LO_W-1:0]};
    assign hi_sum          = s1_vs_hi_q + s1_vc_hi_q + {{(HI_W-1){1'b0}}, s1_cy_q};
    assign full_sum        = {hi_sum, s1_lo_q};
    assign unused_top_bits = full_sum[CS_W-1:P_W];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_cy_d    = s1_cy_q;
        s1_vs_hi_d = s1_vs_hi_q;
        s1_vc_hi_d = s1_vc_hi_q;
`ifdef CSA_TAG_EN
        s1_tag_d   = s1_tag_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lo_d    = lo_sum[LO_W-1:0];
                s1_cy_d    = lo_sum[LO_W];
                s1_vs_hi_d = in_vs[CS_W-1:LO_W];
                s1_vc_hi_d = in_vc[CS_W-1:LO_W];
`ifdef CSA_TAG_EN
                s1_tag_d   = in_tag;
`endif
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
`ifdef CSA_TAG_EN
        s2_tag_d   = s2_tag_q;
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = full_sum[P_W-1:0];
`ifdef CSA_TAG_EN
                s2_tag_d  = s1_tag_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_cy_q    <= 1'b0;
            s1_vs_hi_q <= '0;
            s1_vc_hi_q <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
`ifdef CSA_TAG_EN
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_cy_q    <= s1_cy_d;
            s1_vs_hi_q <= s1_vs_hi_d;
            s1_vc_hi_q <= s1_vc_hi_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
`ifdef CSA_TAG_EN
            s1_tag_q   <= s1_tag_d;
            s2_tag_q   <= s2_tag_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign out_prod  = s2_prod_q;
`ifdef CSA_TAG_EN
    assign out_tag   = s2_tag_q;
`endif
endmodule
